// File: rtl/master_in_port_pkg.sv
// Shared bus definitions for the master-side serial receiver.
// State encoding matches slave_out_port so both ends read the same in waveforms.
package master_in_port_pkg;

  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    RECEIVE = 1'b1
  } state_e;

endpackage

// File: rtl/master_in_port_if.sv
// Receiver bus: serial link from the slave plus valid/ready word output to the master core.
interface master_in_port_if
  import master_in_port_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  rx_data;
  logic                  rx_done;
  logic                  master_ready;
  logic                  data_ready;
  logic                  data_valid;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  frame_error;
  logic                  overrun;

  modport master (
    input  rx_data, rx_done, data_ready,
    output master_ready, data_out, data_valid, frame_error, overrun
  );

  modport slave (
    output rx_data, rx_done, data_ready,
    input  master_ready, data_out, data_valid, frame_error, overrun
  );
endinterface

// File: rtl/master_in_port.sv
// Serial-to-parallel receiver: frame starts on a falling rx_done, DATA_WIDTH bits LSB first,
// word presented on valid/ready with sticky framing and overrun flags.
module master_in_port
  import master_in_port_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_W      = 4
) (
  input logic               clk,
  input logic               reset,
  master_in_port_if.master  bus
);

  state_e                state, state_next;
  logic                  done_q;
  logic                  discard;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift;

  logic                  master_ready_q;
  logic                  data_valid_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  frame_error_q;
  logic                  overrun_q;

  logic start, last, load, take, dv_next;

  // The registered high sample of rx_done makes a low/X strobe out of reset harmless.
  assign start   = (state == IDLE) && done_q && !bus.rx_done;
  assign last    = (state == RECEIVE) && (bit_cnt == CNT_W'(DATA_WIDTH - 1));
  assign load    = last && !discard;
  assign take    = data_valid_q && bus.data_ready;
  assign dv_next = load || (data_valid_q && !take);

  always_comb begin
    state_next = state;
    if (start)     state_next = RECEIVE;
    else if (last) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      done_q         <= 1'b0;
      discard        <= 1'b0;
      bit_cnt        <= '0;
      shift          <= '0;
      master_ready_q <= 1'b0;
      data_valid_q   <= 1'b0;
      data_out_q     <= '0;
      frame_error_q  <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      done_q         <= bus.rx_done;
      state          <= state_next;
      data_valid_q   <= dv_next;
      master_ready_q <= (state_next == IDLE) && !dv_next;
      case (state)
        IDLE: begin
          if (start) begin
            bit_cnt <= '0;
            // Unconsumed word at frame start: keep it, drop the incoming one.
            discard <= data_valid_q && !bus.data_ready;
            if (data_valid_q && !bus.data_ready) overrun_q <= 1'b1;
          end
        end
        RECEIVE: begin
          shift   <= {bus.rx_data, shift[DATA_WIDTH-1:1]};
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (last) begin
            if (!discard)     data_out_q    <= {bus.rx_data, shift[DATA_WIDTH-1:1]};
            if (!bus.rx_done) frame_error_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.master_ready = master_ready_q;
  assign bus.data_valid   = data_valid_q;
  assign bus.data_out     = data_out_q;
  assign bus.frame_error  = frame_error_q;
  assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_master_in_port.sv
// Directed bench for master_in_port: reset, framing, handshake, overrun and mid-frame reset.
module tb_master_in_port;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  master_in_port_if #(.DATA_WIDTH(8)) bus ();

  master_in_port #(.DATA_WIDTH(8), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start edge S then bits on S+1..S+8; rx_done stays low except at glitch_k and on the last bit.
  task automatic run_frame(input logic [7:0] b, input logic last_done, input int glitch_k,
                           output logic mr_seen);
    mr_seen     = 1'b0;
    bus.rx_done = 1'b0;
    tick();
    mr_seen |= bus.master_ready;
    for (int k = 0; k < 8; k++) begin
      bus.rx_data = b[k];
      bus.rx_done = (k == 7) ? last_done : (k == glitch_k);
      tick();
      mr_seen |= bus.master_ready;
    end
    bus.rx_data = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.rx_done = 1'b0; bus.rx_data = 1'b0; bus.data_ready = 1'b0;
    tick(); tick();
    checks++; if ({bus.master_ready, bus.data_valid, bus.data_out, bus.frame_error, bus.overrun} !== 12'h0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", {bus.master_ready, bus.data_valid, bus.data_out, bus.frame_error, bus.overrun}); end
    reset = 1'b0;
    // rx_done low straight out of reset must not start a frame
    tick(); tick();
    checks++; if (bus.master_ready !== 1'b1) begin failures++; $display("FAIL reset_low_done_ready got=%b exp=1", bus.master_ready); end
    checks++; if (bus.data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.data_valid); end
    bus.rx_done = 1'b1;
    tick(); tick(); tick();
    checks++; if (bus.master_ready !== 1'b1) begin failures++; $display("FAIL reset_idle_ready got=%b exp=1", bus.master_ready); end
  endtask

  task automatic test_basic();
    logic mr;
    bus.data_ready = 1'b1;
    run_frame(8'hA5, 1'b1, -1, mr);
    checks++; if (mr !== 1'b0) begin failures++; $display("FAIL a5_ready_during got=%b exp=0", mr); end
    checks++; if (bus.data_valid !== 1'b1) begin failures++; $display("FAIL a5_valid got=%b exp=1", bus.data_valid); end
    checks++; if (bus.data_out !== 8'hA5) begin failures++; $display("FAIL a5_data got=%h exp=a5", bus.data_out); end
    checks++; if (bus.frame_error !== 1'b0) begin failures++; $display("FAIL a5_frame_error got=%b exp=0", bus.frame_error); end
    tick();
    checks++; if (bus.data_valid !== 1'b0) begin failures++; $display("FAIL a5_consumed got=%b exp=0", bus.data_valid); end
    checks++; if (bus.master_ready !== 1'b1) begin failures++; $display("FAIL a5_ready_after got=%b exp=1", bus.master_ready); end
  endtask

  task automatic test_glitch();
    logic mr;
    run_frame(8'h5A, 1'b1, 3, mr);
    checks++; if (bus.data_out !== 8'h5A) begin failures++; $display("FAIL glitch_data got=%h exp=5a", bus.data_out); end
    checks++; if (bus.data_valid !== 1'b1) begin failures++; $display("FAIL glitch_valid got=%b exp=1", bus.data_valid); end
    checks++; if (bus.frame_error !== 1'b0) begin failures++; $display("FAIL glitch_frame_error got=%b exp=0", bus.frame_error); end
    tick();
  endtask

  task automatic test_overrun();
    logic mr;
    bus.data_ready = 1'b0;
    run_frame(8'h3C, 1'b1, -1, mr);
    checks++; if (bus.data_out !== 8'h3C) begin failures++; $display("FAIL ovr_first_data got=%h exp=3c", bus.data_out); end
    tick();
    checks++; if (bus.data_valid !== 1'b1) begin failures++; $display("FAIL ovr_held_valid got=%b exp=1", bus.data_valid); end
    checks++; if (bus.master_ready !== 1'b0) begin failures++; $display("FAIL ovr_held_ready got=%b exp=0", bus.master_ready); end
    checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL ovr_early got=%b exp=0", bus.overrun); end
    run_frame(8'hFF, 1'b1, -1, mr);
    checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", bus.overrun); end
    checks++; if (bus.data_out !== 8'h3C) begin failures++; $display("FAIL ovr_data_kept got=%h exp=3c", bus.data_out); end
    checks++; if (bus.data_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid_kept got=%b exp=1", bus.data_valid); end
    bus.data_ready = 1'b1;
    tick();
    checks++; if (bus.data_valid !== 1'b0) begin failures++; $display("FAIL ovr_drain got=%b exp=0", bus.data_valid); end
    checks++; if (bus.master_ready !== 1'b1) begin failures++; $display("FAIL ovr_ready_after got=%b exp=1", bus.master_ready); end
  endtask

  task automatic test_frame_error();
    logic mr;
    run_frame(8'h81, 1'b0, -1, mr);
    checks++; if (bus.data_out !== 8'h81) begin failures++; $display("FAIL ferr_data got=%h exp=81", bus.data_out); end
    checks++; if (bus.data_valid !== 1'b1) begin failures++; $display("FAIL ferr_valid got=%b exp=1", bus.data_valid); end
    checks++; if (bus.frame_error !== 1'b1) begin failures++; $display("FAIL ferr_flag got=%b exp=1", bus.frame_error); end
    bus.rx_done = 1'b1;
    tick();
    checks++; if (bus.frame_error !== 1'b1) begin failures++; $display("FAIL ferr_sticky got=%b exp=1", bus.frame_error); end
  endtask

  task automatic test_midframe_reset();
    logic mr;
    bus.rx_done = 1'b0;
    tick();
    bus.rx_data = 1'b1; tick();
    bus.rx_data = 1'b1; tick();
    reset = 1'b1;
    #1;
    checks++; if ({bus.master_ready, bus.data_valid, bus.data_out, bus.frame_error, bus.overrun} !== 12'h0) begin
      failures++; $display("FAIL mid_reset_outputs got=%h exp=0", {bus.master_ready, bus.data_valid, bus.data_out, bus.frame_error, bus.overrun}); end
    tick();
    reset = 1'b0;
    // rx_done still low: must wait for a high-then-low before starting
    tick(); tick(); tick();
    checks++; if (bus.master_ready !== 1'b1) begin failures++; $display("FAIL mid_wait_ready got=%b exp=1", bus.master_ready); end
    checks++; if (bus.data_valid !== 1'b0) begin failures++; $display("FAIL mid_no_valid got=%b exp=0", bus.data_valid); end
    bus.rx_done = 1'b1;
    tick();
    run_frame(8'h12, 1'b1, -1, mr);
    checks++; if (bus.data_out !== 8'h12) begin failures++; $display("FAIL mid_clean_data got=%h exp=12", bus.data_out); end
    checks++; if (bus.data_valid !== 1'b1) begin failures++; $display("FAIL mid_clean_valid got=%b exp=1", bus.data_valid); end
    checks++; if ({bus.frame_error, bus.overrun} !== 2'b00) begin failures++; $display("FAIL mid_clean_flags got=%b exp=00", {bus.frame_error, bus.overrun}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_overrun();
    test_frame_error();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
